bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 19 +
 rtl/bus_arbiter_rr_picker.sv | 23 ++
 rtl/bus_arbiter.sv | 71 +++++++
 tb/tb_bus_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// types: shared bus/xbar message formats, transaction kinds and arbiter FSM states
package types;
  localparam int NUM_CPUS = 4;
  localparam int XLEN = 32;
  localparam int SRC_W = $clog2(NUM_CPUS);
  typedef enum logic [1:0] {BUS_RD, BUS_RDX, BUS_UPGR, BUS_WB} bus_tx_t;
  typedef enum logic [1:0] {IDLE, GRANT, WAIT_RESP} arb_state_t;
  typedef struct packed {
    logic valid;
    bus_tx_t bus_tx;
    logic [SRC_W-1:0] source;
    logic [XLEN-1:0] addr;
  } bus_msg_t;
  typedef struct packed {
    logic valid;
    logic [SRC_W-1:0] destination;
    logic [XLEN-1:0] addr;
  } xbar_msg_t;
endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick; req/ptr (first index to consider) in, one-hot gnt and idx out
module rr_picker
  import types::*;
(
  input  logic [NUM_CPUS-1:0] req,
  input  logic [SRC_W-1:0]    ptr,
  output logic [NUM_CPUS-1:0] gnt,
  output logic [SRC_W-1:0]    idx
);
  logic [SRC_W-1:0] c;
  always_comb begin
    gnt = '0;
    idx = '0;
    c = '0;
    for (int i = NUM_CPUS - 1; i >= 0; i--) begin
      c = ptr + SRC_W'(i);
      if (req[c]) begin
        gnt = NUM_CPUS'(1) << c;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin snoop-bus arbiter; req_in/mem_resp in, gnt_out/bus_msg/busy/err out, watchdog on WAIT_RESP
module bus_arbiter
  import types::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  bus_msg_t            req_in [NUM_CPUS],
  output logic [NUM_CPUS-1:0] gnt_out,
  output bus_msg_t            bus_msg,
  input  xbar_msg_t           mem_resp,
  output logic                busy,
  output logic                err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  arb_state_t state;
  logic [SRC_W-1:0] last_owner, ptr, win_idx;
  logic [NUM_CPUS-1:0] req_v, win;
  logic [CW-1:0] cnt;
  logic is_rd, match, expire;
  always_comb begin
    req_v = '0;
    for (int i = 0; i < NUM_CPUS; i++) req_v[i] = req_in[i].valid;
  end
  assign ptr = last_owner + 1'b1;
  rr_picker u_pick (.req(req_v), .ptr(ptr), .gnt(win), .idx(win_idx));
  // bus_msg doubles as the latched request: addr and bus_tx hold after GRANT
  assign is_rd = bus_msg.bus_tx inside {BUS_RD, BUS_RDX};
  assign match = mem_resp.valid && mem_resp.destination == last_owner && mem_resp.addr == bus_msg.addr;
  assign expire = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_owner <= SRC_W'(NUM_CPUS - 1);
      bus_msg <= '0;
      gnt_out <= '0;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      gnt_out <= '0;
      err <= 1'b0;
      bus_msg.valid <= 1'b0;
      case (state)
        IDLE: if (|req_v) begin
          state <= GRANT;
          last_owner <= win_idx;
          gnt_out <= win;
          bus_msg <= req_in[win_idx];
          bus_msg.valid <= 1'b1;
          bus_msg.source <= win_idx;
        end
        GRANT: begin
          state <= is_rd ? WAIT_RESP : IDLE;
          cnt <= '0;
        end
        WAIT_RESP: begin
          cnt <= (cnt == CW'(TIMEOUT_CYCLES)) ? cnt : cnt + 1'b1;
          // a match in the expiry cycle wins over the abort
          if (match) state <= IDLE;
          else if (expire) begin
            state <= IDLE;
            err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed + randomized transactions against a transaction-level arbiter model
module tb_bus_arbiter;
  import types::*;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst;
  bus_msg_t req_in [NUM_CPUS];
  logic [NUM_CPUS-1:0] gnt_out;
  bus_msg_t bus_msg;
  xbar_msg_t mem_resp;
  logic busy, err;
  int tests = 0;
  int fails = 0;
  int last = NUM_CPUS - 1;
  bus_tx_t t_tx [NUM_CPUS];
  logic [XLEN-1:0] t_addr [NUM_CPUS];
  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .gnt_out(gnt_out),
    .bus_msg(bus_msg), .mem_resp(mem_resp), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clear_req();
    for (int i = 0; i < NUM_CPUS; i++) req_in[i].valid = 1'b0;
  endtask
  task automatic txn(input logic [3:0] mask, input int resp_k, input int noise);
    int w;
    logic [XLEN-1:0] a;
    bit rd, done;
    w = -1;
    for (int o = 1; o <= NUM_CPUS; o++)
      if (w < 0 && mask[(last + o) % NUM_CPUS]) w = (last + o) % NUM_CPUS;
    for (int i = 0; i < NUM_CPUS; i++) begin
      req_in[i].valid = mask[i];
      req_in[i].bus_tx = t_tx[i];
      req_in[i].addr = t_addr[i];
      req_in[i].source = 2'(3 - i);
    end
    tick();
    chk("gnt", gnt_out, 64'(1) << w);
    chk("valid", bus_msg.valid, 1);
    chk("source", bus_msg.source, w);
    chk("addr", bus_msg.addr, t_addr[w]);
    chk("bus_tx", bus_msg.bus_tx, t_tx[w]);
    chk("busy_grant", busy, 1);
    last = w;
    a = t_addr[w];
    rd = t_tx[w] == BUS_RD || t_tx[w] == BUS_RDX;
    done = 1'b0;
    clear_req();
    if (rd) for (int k = 1; k <= TO && !done; k++) begin
      tick();
      chk("busy_wait", busy, 1);
      chk("gnt_wait", gnt_out, 0);
      chk("valid_wait", bus_msg.valid, 0);
      chk("err_wait", err, 0);
      for (int i = 0; i < NUM_CPUS; i++) req_in[i].valid = (noise != 0) ? 1'($urandom) : 1'b0;
      if (k == resp_k) begin
        mem_resp = '{valid: 1'b1, destination: 2'(w), addr: a};
        done = 1'b1;
      end else if (noise == 1) mem_resp = '{valid: 1'b1, destination: 2'(w + 2), addr: a};
      else if (noise == 2) mem_resp = '{valid: 1'b1, destination: 2'(w), addr: a ^ 32'h10};
      else mem_resp = '0;
    end
    tick();
    mem_resp = '0;
    clear_req();
    chk("busy_idle", busy, 0);
    chk("err_idle", err, 64'(rd && !done));
    chk("gnt_idle", gnt_out, 0);
    chk("valid_idle", bus_msg.valid, 0);
    chk("hold_addr", bus_msg.addr, a);
    if (rd && !done) begin
      tick();
      chk("err_once", err, 0);
      chk("busy_after", busy, 0);
    end
  endtask
  initial begin
    rst = 1'b1;
    mem_resp = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      req_in[i] = '0;
      t_tx[i] = BUS_RD;
      t_addr[i] = 32'(i);
    end
    tick();
    tick();
    chk("rst_bus", bus_msg, 0);
    chk("rst_gnt", gnt_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    t_tx[0] = BUS_RD;
    t_addr[0] = 32'h5;
    txn(4'b0001, 1, 0);
    t_tx[1] = BUS_RDX;
    t_addr[1] = 32'h100;
    t_tx[3] = BUS_RD;
    t_addr[3] = 32'h300;
    txn(4'b0010, 2, 1);
    txn(4'b1010, 3, 2);
    txn(4'b0010, 1, 0);
    t_tx[2] = BUS_WB;
    t_addr[2] = 32'h200;
    txn(4'b0100, 0, 0);
    txn(4'b0100, 0, 0);
    t_tx[2] = BUS_UPGR;
    txn(4'b0100, 0, 0);
    t_addr[0] = 32'h40;
    txn(4'b0001, 0, 0);
    txn(4'b0001, 5, 1);
    txn(4'b0001, TO, 2);
    t_tx[2] = BUS_RDX;
    for (int i = 0; i < NUM_CPUS; i++) req_in[i] = '{valid: i == 2, bus_tx: t_tx[i], source: 2'(0), addr: t_addr[i]};
    tick();
    chk("mid_gnt", gnt_out, 4'b0100);
    last = 2;
    clear_req();
    tick();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_bus", bus_msg, 0);
    chk("mid_rst_gnt", gnt_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    rst = 1'b0;
    last = NUM_CPUS - 1;
    tick();
    chk("post_rst_err", err, 0);
    for (int i = 0; i < NUM_CPUS; i++) t_tx[i] = BUS_RD;
    txn(4'b1111, 1, 0);
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NUM_CPUS; i++) begin
        t_tx[i] = bus_tx_t'($urandom_range(0, 3));
        t_addr[i] = $urandom;
      end
      txn(4'($urandom_range(1, 15)), $urandom_range(0, TO + 1), $urandom_range(0, 2));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
